phy_tx_fifo: RTL and testbench

Transmit-side elastic buffer sitting directly upstream of `phy`. Accepts 32-bit words from the packet source at arbitrary push rate on `clk`, stores up to DEPTH words, and drains them in order as the `input_bus`/`valid` pair that `phy` samples. It decouples bursty producers from the PHY lane and reports fill level, threshold flags and a sticky overflow error.

---
 rtl/phy_tx_fifo.sv | 125 ++++++++++++
 tb/tb_phy_tx_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/phy_tx_fifo.sv
// phy_tx_fifo: transmit elastic buffer in front of the PHY lane.
// Producer words are written into a small register array and drained in
// order as a registered input_bus/valid pair. Fill level, threshold flags
// and a sticky overflow error are reported alongside.
module phy_tx_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  input  logic              pause,
  output logic [DATA_W-1:0] input_bus,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow
);

  // Fill-level thresholds expressed at the width of the count register.
  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_LEVEL   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0]   AE_LEVEL   = (ADDR_W+1)'(AE_MARGIN);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  // Storage array; contents are deliberately not cleared by reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [DATA_W-1:0] bus_q,    bus_d;
  logic              valid_q,  valid_d;
  logic              ovf_q,    ovf_d;

  logic              full_w;
  logic              empty_w;
  logic              do_pop;
  logic              do_push;

  // Status flags decode the registered count only, so they move on edges.
  assign full_w       = (count_q == FULL_LEVEL);
  assign empty_w      = (count_q == '0);

  // Pop/push decisions use pre-edge state; a pop frees the slot a push on
  // a full FIFO needs, and an empty FIFO never forwards the word being
  // written in the same cycle.
  assign do_pop       = !empty_w && !pause;
  assign do_push      = push && (!full_w || do_pop);

  // Next-state computation for pointers, count, output register and error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bus_d    = bus_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      bus_d    = mem[rd_ptr_q];
      valid_d  = 1'b1;
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A push refused because the FIFO is full and nothing leaves is lost.
    if (push && !do_push) begin
      ovf_d = 1'b1;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Array write port; reset takes priority over a simultaneous push.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign input_bus    = bus_q;
  assign valid        = valid_q;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_phy_tx_fifo.sv
// Self-checking bench for phy_tx_fifo: directed scenarios followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_phy_tx_fifo;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int AF_MARGIN = 2;
  localparam int AE_MARGIN = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pause;
  logic [DATA_W-1:0] input_bus;
  logic              valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;

  phy_tx_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pause(pause),
    .input_bus(input_bus), .valid(valid), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the expected output state.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_bus;
  logic              exp_valid;
  logic              exp_ovf;
  int                n_checks;
  int                n_fail;
  int                cyc;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, compare.
  task automatic step(input logic rst_n, input logic psh, input logic [DATA_W-1:0] din,
                      input logic pse);
    bit pop_ok;
    bit push_ok;
    int sz;
    @(negedge clk);
    reset   = rst_n;
    push    = psh;
    data_in = din;
    pause   = pse;
    sz      = model_q.size();
    pop_ok  = (sz > 0) && !pse;
    push_ok = psh && ((sz < DEPTH) || pop_ok);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_q.delete();
      exp_bus   = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      if (pop_ok) begin
        exp_bus   = model_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (push_ok) model_q.push_back(din);
      if (psh && !push_ok) exp_ovf = 1'b1;
    end
    #1;
    sz = model_q.size();
    $display("cyc=%0d rst_n=%0b push=%0b din=0x%08h pause=%0b -> valid=%0b bus=0x%08h count=%0d ovf=%0b",
             cyc, rst_n, psh, din, pse, valid, input_bus, count, overflow);
    check_eq("valid", 64'(valid), 64'(exp_valid));
    if (exp_valid || !rst_n) check_eq("input_bus", 64'(input_bus), 64'(exp_bus));
    check_eq("count", 64'(count), 64'(sz));
    check_eq("full", 64'(full), 64'(sz == DEPTH));
    check_eq("empty", 64'(empty), 64'(sz == 0));
    check_eq("almost_full", 64'(almost_full), 64'(sz >= DEPTH - AF_MARGIN));
    check_eq("almost_empty", 64'(almost_empty), 64'(sz <= AE_MARGIN));
    check_eq("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    exp_bus   = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    reset     = 1'b0;
    push      = 1'b0;
    pause     = 1'b0;
    data_in   = '0;

    // Reset held two edges while pushing: nothing must be stored.
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0);

    // Single word: one-cycle latency, one-cycle valid.
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(3);

    // Fill past capacity while paused, then drain.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
    idle(10);

    // Push on full with simultaneous pop is accepted.
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h10 + 32'(i), 1'b1);
    step(1'b1, 1'b1, 32'hAAAA_0000, 1'b0);
    idle(10);

    // Streaming across pointer wrap with periodic pause.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h100 + 32'(i), (i % 3) == 2);
    idle(10);

    // Reset mid-operation discards stored words.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'hC0 + 32'(i), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h55, 1'b0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic r_rst;
      logic r_psh;
      logic r_pse;
      r_rst = ($urandom_range(0, 79) != 0);
      r_psh = ($urandom_range(0, 99) < 60);
      r_pse = ($urandom_range(0, 99) < 35);
      step(r_rst, r_psh, $urandom, r_pse);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
